// File: rtl/paillier_pkg.sv
// Shared command codes, driver state encoding and command legality check for the Paillier task driver.
// Pure declarations: no logic, latency or backpressure of its own.
package paillier_pkg;

    localparam logic [2:0] CMD_ENC  = 3'b000;
    localparam logic [2:0] CMD_DEC  = 3'b001;
    localparam logic [2:0] CMD_ADD  = 3'b010;
    localparam logic [2:0] CMD_SMUL = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_STREAM,
        ST_WAIT_RES,
        ST_DONE
    } drv_state_t;

    function automatic logic cmd_legal(input logic [2:0] c);
        return (c == CMD_ENC) || (c == CMD_DEC) || (c == CMD_ADD) || (c == CMD_SMUL);
    endfunction

endpackage

// File: rtl/word_bank.sv
// N x K synchronous RAM, one write and one read port; read data registered one cycle after raddr.
// No backpressure; rdata holds while re is low, and a same-cycle read of the written word returns the old word.
module word_bank #(
    parameter int K = 128,
    parameter int N = 32,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [K-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [K-1:0]  rdata
);

    logic [K-1:0] mem [N];

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/paillier_task_driver.sv
// Host-side initiator: loads three operand banks, issues a one-cycle task request, streams N words, captures N results.
// All outputs registered; no operand backpressure (engine must accept every word); timeout aborts a stalled task.
module paillier_task_driver
    import paillier_pkg::*;
#(
    parameter int K         = 128,
    parameter int N         = 32,
    parameter int START_GAP = 1,
    parameter int TIMEOUT   = 1 << 20,
    localparam int AW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [K-1:0]  wr_data,
    input  logic          start,
    input  logic [2:0]    cmd,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] rd_addr,
    output logic [K-1:0]  rd_data,
    output logic [2:0]    task_cmd,
    output logic          task_req,
    output logic [K-1:0]  op0_data,
    output logic [K-1:0]  op1_data,
    output logic [K-1:0]  op2_data,
    output logic          op_valid,
    input  logic [K-1:0]  res_data,
    input  logic          res_valid
);

    localparam logic [31:0] GAP_LAST = (START_GAP > 1) ? 32'(START_GAP - 2) : 32'd0;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    drv_state_t    state, state_next;
    logic [AW-1:0] str_cnt;
    logic [AW-1:0] res_cnt;
    logic [31:0]   gap_cnt;
    logic [31:0]   tmo_cnt;

    logic          in_capture;
    logic          capture;
    logic          last_res;
    logic          tmo_hit;
    logic          accept;
    logic          reject;
    logic          op_re;
    logic [AW-1:0] op_raddr;
    logic [K-1:0]  op_rdata [3];

    assign in_capture = (state == ST_STREAM) || (state == ST_WAIT_RES);
    assign capture    = in_capture && res_valid;
    assign last_res   = capture && (res_cnt == AW'(N - 1));
    assign tmo_hit    = in_capture && (tmo_cnt == TMO_LAST);
    assign accept     = (state == ST_IDLE) && start && cmd_legal(cmd);
    assign reject     = (state == ST_IDLE) && start && !cmd_legal(cmd);

    // Operand address runs one word ahead so the bank output register is the operand output.
    assign op_re    = (state_next == ST_STREAM);
    assign op_raddr = (state == ST_STREAM) ? str_cnt + AW'(1) : '0;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_REQ;
            end
            ST_REQ: begin
                state_next = (START_GAP > 1) ? ST_GAP : ST_STREAM;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (last_res)                      state_next = ST_DONE;
                else if (tmo_hit)                  state_next = ST_IDLE;
                else if (str_cnt == AW'(N - 1))    state_next = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (last_res)      state_next = ST_DONE;
                else if (tmo_hit)  state_next = ST_IDLE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            str_cnt  <= '0;
            res_cnt  <= '0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            task_req <= 1'b0;
            task_cmd <= '0;
            op_valid <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done     <= (state_next == ST_DONE);
            task_req <= (state_next == ST_REQ);
            task_cmd <= accept ? cmd : 3'b000;
            op_valid <= (state_next == ST_STREAM);

            if (accept) begin
                err <= 1'b0;
            end else if (reject || (tmo_hit && !last_res)) begin
                err <= 1'b1;
            end

            str_cnt <= op_re ? op_raddr : '0;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 32'd1 : 32'd0;
            tmo_cnt <= in_capture ? tmo_cnt + 32'd1 : 32'd0;

            if (capture) begin
                res_cnt <= res_cnt + AW'(1);
            end else if (!in_capture) begin
                res_cnt <= '0;
            end
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_op_bank
        word_bank #(.K(K), .N(N)) u_op_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_en && (state == ST_IDLE) && (wr_bank == 2'(b))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (op_re),
            .raddr (op_raddr),
            .rdata (op_rdata[b])
        );
    end

    assign op0_data = op_rdata[0];
    assign op1_data = op_rdata[1];
    assign op2_data = op_rdata[2];

    word_bank #(.K(K), .N(N)) u_res_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (capture),
        .waddr (res_cnt),
        .wdata (res_data),
        .re    (1'b1),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_paillier_task_driver.sv
// Directed bench for paillier_task_driver with TIMEOUT shortened to 64 cycles.
module tb_paillier_task_driver;
    import paillier_pkg::*;

    localparam int K  = 128;
    localparam int N  = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_bank;
    logic [AW-1:0] wr_addr;
    logic [K-1:0]  wr_data;
    logic          start;
    logic [2:0]    cmd;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] rd_addr;
    logic [K-1:0]  rd_data;
    logic [2:0]    task_cmd;
    logic          task_req;
    logic [K-1:0]  op0_data;
    logic [K-1:0]  op1_data;
    logic [K-1:0]  op2_data;
    logic          op_valid;
    logic [K-1:0]  res_data;
    logic          res_valid;

    int checks = 0;
    int errors = 0;

    paillier_task_driver #(.K(K), .N(N), .START_GAP(1), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .cmd       (cmd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .task_cmd  (task_cmd),
        .task_req  (task_req),
        .op0_data  (op0_data),
        .op1_data  (op1_data),
        .op2_data  (op2_data),
        .op_valid  (op_valid),
        .res_data  (res_data),
        .res_valid (res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input logic [1:0] b, input int a, input logic [K-1:0] d);
        wr_en = 1'b1; wr_bank = b; wr_addr = AW'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the task_req cycle.
    task automatic launch(input logic [2:0] c);
        start = 1'b1; cmd = c;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, task_req, op_valid} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags got busy/done/err/req/valid=%b want 00000", {busy, done, err, task_req, op_valid});
        end
        checks++;
        if (task_cmd !== 3'b000) begin
            errors++; $display("FAIL reset_task_cmd got %b want 000", task_cmd);
        end
        checks++;
        if (op0_data !== '0 || op1_data !== '0 || op2_data !== '0) begin
            errors++; $display("FAIL reset_op_data got %h %h %h want 0", op0_data, op1_data, op2_data);
        end
        checks++;
        if (rd_data !== '0) begin
            errors++; $display("FAIL reset_rd_data got %h want 0", rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_stream;
        int late_done;
        for (int i = 0; i < N; i++) begin
            write_word(2'd0, i, K'(i));
            write_word(2'd1, i, K'(32'h100 + i));
            write_word(2'd2, i, K'(32'h200 + i));
        end
        launch(CMD_ENC);
        checks++;
        if (task_req !== 1'b1 || task_cmd !== CMD_ENC || busy !== 1'b1) begin
            errors++; $display("FAIL launch_enc got req=%b cmd=%b busy=%b want 1 000 1", task_req, task_cmd, busy);
        end
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    @(negedge clk);
                    checks++;
                    if (op_valid !== 1'b1 || task_req !== 1'b0 || op0_data !== K'(i) ||
                        op1_data !== K'(32'h100 + i) || op2_data !== K'(32'h200 + i)) begin
                        errors++;
                        $display("FAIL stream_word%0d got valid=%b req=%b op0=%h op1=%h op2=%h want 1 0 %h %h %h",
                                 i, op_valid, task_req, op0_data, op1_data, op2_data, i, 32'h100 + i, 32'h200 + i);
                    end
                end
                @(negedge clk);
                checks++;
                if (op_valid !== 1'b0) begin
                    errors++; $display("FAIL stream_end got op_valid=%b want 0", op_valid);
                end
            end
            begin
                for (int j = 0; j < N; j++) begin
                    if (j % 2 == 1 && $urandom_range(0, 1) == 1) begin
                        @(negedge clk);
                        res_valid = 1'b0;
                    end
                    @(negedge clk);
                    res_valid = 1'b1;
                    res_data  = K'(32'hA000 + j);
                end
                @(negedge clk);
                res_valid = 1'b0;
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL done_pulse got done=%b busy=%b want 1 0", done, busy);
                end
            end
        join
        late_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            late_done += int'(done);
        end
        checks++;
        if (late_done != 0) begin
            errors++; $display("FAIL done_once got %0d extra done cycles want 0", late_done);
        end
        for (int j = 0; j < N; j++) begin
            rd_addr = AW'(j);
            @(negedge clk);
            checks++;
            if (rd_data !== K'(32'hA000 + j)) begin
                errors++; $display("FAIL result_read%0d got %h want %h", j, rd_data, 32'hA000 + j);
            end
        end
    endtask

    // Leaves a CMD_DEC task in flight at its task_req cycle for test_timeout.
    task automatic test_illegal_cmd;
        start = 1'b1; cmd = 3'b101;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL illegal_err got %b want 1", err);
        end
        checks++;
        if (busy !== 1'b0 || task_req !== 1'b0) begin
            errors++; $display("FAIL illegal_no_req got busy=%b req=%b want 0 0", busy, task_req);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || task_req !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL illegal_sticky got busy=%b req=%b err=%b want 0 0 1", busy, task_req, err);
        end
        launch(CMD_DEC);
        checks++;
        if (err !== 1'b0 || task_req !== 1'b1 || task_cmd !== CMD_DEC) begin
            errors++; $display("FAIL err_clear got err=%b req=%b cmd=%b want 0 1 001", err, task_req, task_cmd);
        end
    endtask

    task automatic test_timeout;
        logic seen_done;
        seen_done = 1'b0;
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b1) begin
            errors++; $display("FAIL tmo_first_word got op_valid=%b want 1", op_valid);
        end
        for (int k = 1; k <= 64; k++) begin
            res_valid = (k <= 5);
            res_data  = K'(k);
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
            if (k == 63) begin
                checks++;
                if (err !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL tmo_early got err=%b busy=%b at +63 want 0 1", err, busy);
                end
            end
            if (k == 64) begin
                checks++;
                if (err !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL tmo_fire got err=%b busy=%b at +64 want 1 0", err, busy);
                end
            end
        end
        res_valid = 1'b0;
        checks++;
        if (seen_done !== 1'b0) begin
            errors++; $display("FAIL tmo_no_done got done seen=%b want 0", seen_done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL tmo_idle got busy=%b err=%b want 0 1", busy, err);
        end
    endtask

    task automatic test_busy_lockout;
        int req_cnt;
        int done_cnt;
        req_cnt = 0;
        done_cnt = 0;
        launch(CMD_SMUL);
        checks++;
        if (task_req !== 1'b1 || task_cmd !== CMD_SMUL || err !== 1'b0) begin
            errors++; $display("FAIL launch_smul got req=%b cmd=%b err=%b want 1 011 0", task_req, task_cmd, err);
        end
        fork
            begin
                repeat (6) @(negedge clk);
                wr_en = 1'b1; wr_bank = 2'd0; wr_addr = '0; wr_data = K'(32'hDEAD);
                start = 1'b1; cmd = CMD_ENC;
                @(negedge clk);
                wr_en = 1'b0; start = 1'b0;
            end
            begin
                for (int j = 0; j < N; j++) begin
                    @(negedge clk);
                    res_valid = 1'b1;
                    res_data  = K'(32'hB000 + j);
                end
                @(negedge clk);
                res_valid = 1'b0;
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL lockout_done got done=%b busy=%b want 1 0", done, busy);
                end
            end
            begin
                repeat (36) begin
                    @(negedge clk);
                    req_cnt  += int'(task_req);
                    done_cnt += int'(done);
                end
            end
        join
        checks++;
        if (req_cnt != 0) begin
            errors++; $display("FAIL lockout_start got %0d task_req cycles want 0", req_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL lockout_done_count got %0d want 1", done_cnt);
        end
        rd_addr = '0;
        @(negedge clk);
        checks++;
        if (rd_data !== K'(32'hB000)) begin
            errors++; $display("FAIL lockout_res0 got %h want b000", rd_data);
        end
        rd_addr = AW'(31);
        @(negedge clk);
        checks++;
        if (rd_data !== K'(32'hB01F)) begin
            errors++; $display("FAIL lockout_res31 got %h want b01f", rd_data);
        end
    endtask

    task automatic test_reset_mid_task;
        launch(CMD_ENC);
        @(negedge clk);
        checks++;
        if (op_valid !== 1'b1 || op0_data !== K'(0) || op1_data !== K'(32'h100)) begin
            errors++; $display("FAIL lockout_bank0 got valid=%b op0=%h op1=%h want 1 0 100", op_valid, op0_data, op1_data);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (op_valid !== 1'b1 || op0_data !== K'(10)) begin
            errors++; $display("FAIL word10 got valid=%b op0=%h want 1 a", op_valid, op0_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (op_valid !== 1'b0 || busy !== 1'b0 || task_req !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_flags got valid=%b busy=%b req=%b done=%b want 0 0 0 0", op_valid, busy, task_req, done);
        end
        checks++;
        if (op0_data !== '0 || rd_data !== '0) begin
            errors++; $display("FAIL midreset_data got op0=%h rd=%h want 0 0", op0_data, rd_data);
        end
        @(negedge clk);
        launch(CMD_ADD);
        checks++;
        if (task_req !== 1'b1 || task_cmd !== CMD_ADD) begin
            errors++; $display("FAIL fresh_launch got req=%b cmd=%b want 1 010", task_req, task_cmd);
        end
        for (int j = 0; j < N; j++) begin
            @(negedge clk);
            if (j == 0) begin
                checks++;
                if (op_valid !== 1'b1 || op0_data !== K'(0) || op2_data !== K'(32'h200)) begin
                    errors++; $display("FAIL fresh_word0 got valid=%b op0=%h op2=%h want 1 0 200", op_valid, op0_data, op2_data);
                end
            end
            res_valid = 1'b1;
            res_data  = K'(32'hC000 + j);
        end
        @(negedge clk);
        res_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL fresh_done got done=%b busy=%b err=%b want 1 0 0", done, busy, err);
        end
        rd_addr = AW'(7);
        @(negedge clk);
        checks++;
        if (rd_data !== K'(32'hC007)) begin
            errors++; $display("FAIL fresh_read7 got %h want c007", rd_data);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; cmd = '0; rd_addr = '0; res_data = '0; res_valid = 1'b0;
        test_reset;
        test_write_stream;
        test_illegal_cmd;
        test_timeout;
        test_busy_lockout;
        test_reset_mid_task;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish within 100000 time units want finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
